bsg_counter_window_sampler: RTL and testbench

BSG_COUNTER_WINDOW_SAMPLER -- requirements
Module: bsg_counter_window_sampler

---
 rtl/bsg_counter_window_sampler.sv | 126 ++++++++++++
 tb/tb_bsg_counter_window_sampler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_counter_window_sampler.sv
// Windowed sampler for an upstream clear/up counter: clears it every window_cycles_p cycles and
// buffers {seq, count} in a one-entry output register. Define BSG_COUNTER_WINDOW_SAMPLER_DROP_CNT_EN to add drop_cnt_o.
`timescale 1ns/1ps
module bsg_counter_window_sampler #(
  parameter int unsigned width_p         = 31,
  parameter int unsigned window_cycles_p = 1024,
  parameter int unsigned seq_width_p     = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             en_i,
  input  logic [width_p-1:0]               count_i,
  output logic                             clear_o,
  output logic                             v_o,
  output logic [seq_width_p+width_p-1:0]   data_o,
  input  logic                             yumi_i,
  output logic                             overflow_o
`ifdef BSG_COUNTER_WINDOW_SAMPLER_DROP_CNT_EN
  ,
  output logic [15:0]                      drop_cnt_o
`endif
);

  typedef enum logic {eIdle, eRun} state_e;

  localparam logic [31:0] last_win_lp = 32'(window_cycles_p - 1);

  state_e                            state_q, state_d;
  logic [31:0]                       win_q, win_d;
  logic [seq_width_p-1:0]            seq_q, seq_d;
  logic                              v_q, v_d;
  logic [seq_width_p+width_p-1:0]    data_q, data_d;
  logic                              ovf_q, ovf_d;
  logic                              terminal;
  logic                              run_clr;

  assign terminal = (state_q == eRun) && (win_q == last_win_lp);
  // Leaving RUN wipes run state immediately so IDLE shows cleared values from its first cycle.
  assign run_clr  = (state_q == eIdle) || !en_i;

  assign clear_o    = (state_q == eIdle) || terminal;
  assign v_o        = v_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    seq_d   = seq_q;
    v_d     = v_q;
    data_d  = data_q;
    ovf_d   = ovf_q;

    if (v_q && yumi_i) v_d = 1'b0;

    case (state_q)
      eIdle: begin
        win_d = '0;
        seq_d = '0;
        ovf_d = 1'b0;
        if (en_i) state_d = eRun;
      end
      eRun: begin
        if (!en_i) begin
          state_d = eIdle;
          win_d   = '0;
          seq_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          win_d = terminal ? '0 : win_q + 32'd1;
          if (terminal) begin
            seq_d = seq_q + seq_width_p'(1);
            if (!v_q || yumi_i) begin
              v_d    = 1'b1;
              data_d = {seq_q, count_i};
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      win_q   <= '0;
      seq_q   <= '0;
      v_q     <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      seq_q   <= seq_d;
      v_q     <= v_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef BSG_COUNTER_WINDOW_SAMPLER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop_now;

  assign drop_now   = terminal && en_i && v_q && !yumi_i;
  assign drop_cnt_o = drop_cnt_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (run_clr)                        drop_cnt_d = '0;
    else if (drop_now && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end
`else
  logic unused_run_clr;
  assign unused_run_clr = run_clr;
`endif

endmodule

// File: tb/tb_bsg_counter_window_sampler.sv
// Bench for bsg_counter_window_sampler: vector table, directed window scenarios and
// random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_bsg_counter_window_sampler;
  localparam int unsigned W  = 31;
  localparam int unsigned N  = 4;
  localparam int unsigned S  = 8;
  localparam int unsigned DW = S + W;

  logic          clk = 1'b0;
  logic          reset, en, yumi;
  logic [W-1:0]  cnt;
  logic          clear, v, ovf;
  logic [DW-1:0] data;
`ifdef BSG_COUNTER_WINDOW_SAMPLER_DROP_CNT_EN
  logic [15:0]   dcnt;
`endif

  always #5 clk = ~clk;

  bsg_counter_window_sampler #(
    .width_p(W), .window_cycles_p(N), .seq_width_p(S)
  ) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .count_i(cnt),
    .clear_o(clear), .v_o(v), .data_o(data), .yumi_i(yumi), .overflow_o(ovf)
`ifdef BSG_COUNTER_WINDOW_SAMPLER_DROP_CNT_EN
    , .drop_cnt_o(dcnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: window position, tag, and a one-deep queue of offered samples.
  bit            m_run;
  int unsigned   m_idx, m_seq, m_drops;
  bit            m_ovf;
  logic [DW-1:0] m_buf[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] smp(input int unsigned sq, input int unsigned c);
    return {S'(sq), W'(c)};
  endfunction

  function automatic void model_reset();
    m_run = 0; m_idx = 0; m_seq = 0; m_drops = 0; m_ovf = 0;
    m_buf.delete();
  endfunction

  function automatic void model_step(input bit e, input bit y, input logic [W-1:0] c);
    bit term;
    term = m_run && (m_idx == N - 1);
    if (y && m_buf.size() != 0) m_buf.delete(0);
    if (!m_run || !e) begin
      m_run = !m_run && e;
      m_idx = 0; m_seq = 0; m_ovf = 0; m_drops = 0;
    end else begin
      if (term) begin
        if (m_buf.size() == 0) m_buf.push_back({S'(m_seq), c});
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
        m_seq = (m_seq + 1) % (2 ** S);
      end
      m_idx = (m_idx + 1) % N;
    end
  endfunction

  task automatic compare_model();
    chk("model_clear", 64'(clear), 64'(!m_run || m_idx == N - 1));
    chk("model_v", 64'(v), 64'(m_buf.size() != 0));
    if (m_buf.size() != 0) chk("model_data", 64'(data), 64'(m_buf[0]));
    chk("model_ovf", 64'(ovf), 64'(m_ovf));
`ifdef BSG_COUNTER_WINDOW_SAMPLER_DROP_CNT_EN
    chk("model_dropcnt", 64'(dcnt), 64'(m_drops));
`endif
  endtask

  task automatic tick(input bit e, input bit y, input logic [W-1:0] c);
    en = e; yumi = y; cnt = c;
    @(posedge clk);
    model_step(e, y, c);
    #1;
    compare_model();
  endtask

  // From window position 0: runs to the terminal cycle, offering c there.
  task automatic window(input int unsigned c, input bit y);
    for (int unsigned k = 0; k < N - 1; k++) tick(1'b1, y, '0);
    tick(1'b1, y, W'(c));
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; yumi = 1'b0; cnt = '0;
    #2;
    model_reset();
    chk("rst_clear", 64'(clear), 64'd1);
    chk("rst_v", 64'(v), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_clear", 64'(clear), 64'd1);
  endtask

  typedef struct {
    bit            en;
    bit            yumi;
    logic [W-1:0]  cnt;
    bit            e_clear;
    bit            e_v;
    logic [DW-1:0] e_data;
    bit            e_ovf;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input bit e, input bit y, input int unsigned c,
                              input bit ec, input bit ev, input int unsigned sq,
                              input int unsigned dc);
    vec_t r;
    r.en = e; r.yumi = y; r.cnt = W'(c);
    r.e_clear = ec; r.e_v = ev; r.e_data = smp(sq, dc); r.e_ovf = 1'b0;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 5, 0, 1, 0, 5);
    tbl[5]  = mk(1, 0, 0, 0, 1, 0, 5);
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 5);
    tbl[7]  = mk(1, 0, 0, 1, 1, 0, 5);
    tbl[8]  = mk(1, 1, 9, 0, 1, 1, 9);
    tbl[9]  = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].en, tbl[i].yumi, tbl[i].cnt);
      chk($sformatf("vec%0d_clear", i), 64'(clear), 64'(tbl[i].e_clear));
      chk($sformatf("vec%0d_v", i), 64'(v), 64'(tbl[i].e_v));
      if (tbl[i].e_v) chk($sformatf("vec%0d_data", i), 64'(data), 64'(tbl[i].e_data));
      chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(tbl[i].e_ovf));
    end

    // Consumer always ready: three consecutive windows, tags 0..2.
    do_reset();
    tick(1'b1, 1'b1, '0);
    for (int unsigned k = 1; k <= 3; k++) begin
      window(k, 1'b1);
      chk($sformatf("ready_w%0d_v", k), 64'(v), 64'd1);
      chk($sformatf("ready_w%0d_data", k), 64'(data), 64'(smp(k - 1, k)));
      chk($sformatf("ready_w%0d_ovf", k), 64'(ovf), 64'd0);
    end

    // Stalled consumer: second sample is dropped, tag gap shows on the next capture.
    do_reset();
    tick(1'b1, 1'b0, '0);
    window(7, 1'b0);
    chk("stall_first_data", 64'(data), 64'(smp(0, 7)));
    window(8, 1'b0);
    chk("stall_held_data", 64'(data), 64'(smp(0, 7)));
    chk("stall_held_v", 64'(v), 64'd1);
    chk("stall_ovf", 64'(ovf), 64'd1);
`ifdef BSG_COUNTER_WINDOW_SAMPLER_DROP_CNT_EN
    chk("stall_dropcnt", 64'(dcnt), 64'd1);
`endif
    tick(1'b1, 1'b1, '0);
    chk("stall_retire_v", 64'(v), 64'd0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, W'(11));
    chk("stall_next_data", 64'(data), 64'(smp(2, 11)));
    chk("stall_ovf_sticky", 64'(ovf), 64'd1);

    // Disable in the second cycle of a window, then re-enable.
    do_reset();
    tick(1'b1, 1'b1, '0);
    window(3, 1'b1);
    tick(1'b1, 1'b1, '0);
    tick(1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle%0d_clear", k), 64'(clear), 64'd1);
      chk($sformatf("idle%0d_v", k), 64'(v), 64'd0);
      tick(1'b0, 1'b0, W'(k + 20));
    end
    tick(1'b1, 1'b0, '0);
    chk("reen_clear", 64'(clear), 64'd0);
    window(4, 1'b0);
    chk("reen_data", 64'(data), 64'(smp(0, 4)));

    // Sample survives disable and stays offered until accepted.
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("idle_keep_v", 64'(v), 64'd1);
    chk("idle_keep_data", 64'(data), 64'(smp(0, 4)));
    tick(1'b0, 1'b1, '0);
    chk("idle_accept_v", 64'(v), 64'd0);

    // Asynchronous reset mid-cycle with a sample buffered.
    do_reset();
    tick(1'b1, 1'b0, '0);
    window(6, 1'b0);
    window(7, 1'b0);
    chk("pre_async_v", 64'(v), 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_v", 64'(v), 64'd0);
    chk("async_ovf", 64'(ovf), 64'd0);
    chk("async_data", 64'(data), 64'd0);
    chk("async_clear", 64'(clear), 64'd1);
    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("async_post_clear", 64'(clear), 64'd1);

    // Random traffic, including illegal yumi while empty.
    for (int i = 0; i < 3000; i++)
      tick(($urandom % 16) != 0, ($urandom % 3) == 0, W'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
